// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//   Issuing side of a W-bit ALU port. Accepts one operation at a time over a
//   valid/ready request channel and drives the ALU for one or more passes.
//   It collects the ALU result and carry, and returns a result plus flags over
//   a valid/ready response channel.
//   Double-word (2*W) operations take a low pass and a high pass. Add/sub take
//   an extra FIX pass that folds the low-half carry/borrow into the high half.
//   The architectural flag register r_flg {Z,CY,S,P,OV} lives here.
//
//   Optional feature: define ALU_SEQ_PERF_EN to add o_perf_ops (completed
//   responses) and o_perf_fix (FIX passes), both 16-bit wrapping counters.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_req_*, o_req_ready  request: opcode, wide, operands A/B (2W each)
//   o_rsp_*, i_rsp_ready  response: result (2W, upper half 0 if narrow), flags
//   o_alu_*               ALU drive: opcode, arg1, arg2, in_flg, block_cy_ov
//   i_alu_res/out_flg     ALU return (combinational); only out_flg[3] used
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int          W       = 16,
  parameter logic [4:0]  FLG_RST = 5'b0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [2:0]      i_req_opcode,
  input  logic            i_req_wide,
  input  logic [2*W-1:0]  i_req_a,
  input  logic [2*W-1:0]  i_req_b,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [2*W-1:0]  o_rsp_res,
  output logic [4:0]      o_rsp_flg,
  output logic [2:0]      o_alu_opcode,
  output logic [W-1:0]    o_alu_arg1,
  output logic [W-1:0]    o_alu_arg2,
  output logic [4:0]      o_alu_in_flg,
  output logic            o_alu_block_cy_ov,
  input  logic [W-1:0]    i_alu_res,
  input  logic [4:0]      i_alu_out_flg
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [15:0]     o_perf_ops,
  output logic [15:0]     o_perf_fix
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_FIX, S_RESP} state_t;

  state_t           r_state, w_nxt;
  logic [2:0]       r_op;
  logic             r_wide;
  logic [2*W-1:0]   r_a, r_b;
  logic [W-1:0]     r_lo, r_hi;
  logic             r_cy0, r_cy1;
  logic [4:0]       r_flg;

  logic             w_addsub, w_pass, w_fix_needed, w_done, w_cy_alu;
  logic [2*W-1:0]   w_res_fin;
  logic             w_cy_fin, w_a_msb, w_b_msb, w_r_msb, w_ov;
  logic [4:0]       w_flg_new;
  logic [3:0]       w_unused_flg;

  assign w_addsub     = (r_op == 3'b000) || (r_op == 3'b001);
  assign w_pass       = r_op[2] & r_op[1];
  assign w_fix_needed = w_addsub & r_cy0;
  assign w_cy_alu     = i_alu_out_flg[3];
  assign w_unused_flg = {i_alu_out_flg[4], i_alu_out_flg[2:0]};

  // ---------------- state register ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_nxt;
  end

  // ---------------- next state ----------------
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_req_valid) w_nxt = S_LO;
      S_LO:   w_nxt = r_wide ? S_HI : S_RESP;
      S_HI:   w_nxt = w_fix_needed ? S_FIX : S_RESP;
      S_FIX:  w_nxt = S_RESP;
      S_RESP: if (i_rsp_ready) w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    o_alu_opcode = '0;
    o_alu_arg1   = '0;
    o_alu_arg2   = '0;
    case (r_state)
      S_LO: begin
        o_alu_opcode = r_op;
        o_alu_arg1   = r_a[W-1:0];
        o_alu_arg2   = r_b[W-1:0];
      end
      S_HI: begin
        o_alu_opcode = r_op;
        o_alu_arg1   = r_a[2*W-1:W];
        o_alu_arg2   = r_b[2*W-1:W];
      end
      // Same opcode with arg 1: add applies the carry, sub applies the borrow.
      S_FIX: begin
        o_alu_opcode = r_op;
        o_alu_arg1   = r_hi;
        o_alu_arg2   = W'(1);
      end
      default: ;
    endcase
  end

  assign o_req_ready       = (r_state == S_IDLE);
  assign o_rsp_valid       = (r_state == S_RESP);
  assign o_rsp_res         = {r_hi, r_lo};
  assign o_rsp_flg         = r_flg;
  assign o_alu_in_flg      = r_flg;
  assign o_alu_block_cy_ov = 1'b0;

  // ---------------- flags on the final pass ----------------
  // The final result is assembled from the live ALU output so flags can be
  // written on the same edge that enters RESP.
  assign w_res_fin = (r_state == S_LO) ? {{W{1'b0}}, i_alu_res} : {i_alu_res, r_lo};
  // A high-half carry and a FIX carry cannot both occur, so OR gives the total.
  assign w_cy_fin  = (r_state == S_FIX) ? (r_cy1 | w_cy_alu) : w_cy_alu;
  assign w_a_msb   = r_wide ? r_a[2*W-1]       : r_a[W-1];
  assign w_b_msb   = r_wide ? r_b[2*W-1]       : r_b[W-1];
  assign w_r_msb   = r_wide ? w_res_fin[2*W-1] : w_res_fin[W-1];

  always_comb begin
    w_ov = 1'b0;
    if (r_op == 3'b000)      w_ov = (w_a_msb == w_b_msb) && (w_r_msb != w_a_msb);
    else if (r_op == 3'b001) w_ov = (w_a_msb != w_b_msb) && (w_r_msb != w_a_msb);
    if (w_pass)
      w_flg_new = {~|w_res_fin, r_flg[3], w_r_msb, ^w_res_fin, r_flg[0]};
    else
      w_flg_new = {~|w_res_fin, w_addsub & w_cy_fin, w_r_msb, ^w_res_fin, w_ov};
  end

  assign w_done = (w_nxt == S_RESP) && (r_state != S_RESP);

  // ---------------- datapath ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op   <= '0;
      r_wide <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_lo   <= '0;
      r_hi   <= '0;
      r_cy0  <= 1'b0;
      r_cy1  <= 1'b0;
      r_flg  <= FLG_RST;
    end else begin
      case (r_state)
        S_IDLE: if (i_req_valid) begin
          r_op   <= i_req_opcode;
          r_wide <= i_req_wide;
          r_a    <= i_req_a;
          r_b    <= i_req_b;
          r_hi   <= '0;  // narrow results must read back with a zero upper half
        end
        S_LO: begin
          r_lo  <= i_alu_res;
          r_cy0 <= w_cy_alu;
        end
        S_HI: begin
          r_hi  <= i_alu_res;
          r_cy1 <= w_cy_alu;
        end
        S_FIX: r_hi <= i_alu_res;
        default: ;
      endcase
      if (w_done) r_flg <= w_flg_new;
    end
  end

`ifdef ALU_SEQ_PERF_EN
  logic [15:0] r_perf_ops, r_perf_fix;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_perf_ops <= '0;
      r_perf_fix <= '0;
    end else begin
      if (o_rsp_valid && i_rsp_ready)              r_perf_ops <= r_perf_ops + 16'd1;
      if ((r_state == S_HI) && (w_nxt == S_FIX))   r_perf_fix <= r_perf_fix + 16'd1;
    end
  end
  assign o_perf_ops = r_perf_ops;
  assign o_perf_fix = r_perf_fix;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_wide, rsp_valid, rsp_ready, alu_block;
  logic [2:0]    req_opcode, alu_opcode;
  logic [31:0]   req_a, req_b, rsp_res;
  logic [4:0]    rsp_flg, alu_in_flg, alu_out_flg;
  logic [15:0]   alu_arg1, alu_arg2, alu_res;
  logic          alu_c;
  logic [3:0]    junk;

  int n_chk = 0;
  int n_fail = 0;
  logic [4:0]  m_flg;     // reference copy of the architectural flags
  logic [31:0] l_res;     // last observed response
  logic [4:0]  l_flg;

  always #5 clk = ~clk;

  alu_op_sequencer #(.W(W), .FLG_RST(5'b0)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_opcode(req_opcode),
    .i_req_wide(req_wide), .i_req_a(req_a), .i_req_b(req_b),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_res(rsp_res), .o_rsp_flg(rsp_flg),
    .o_alu_opcode(alu_opcode), .o_alu_arg1(alu_arg1), .o_alu_arg2(alu_arg2),
    .o_alu_in_flg(alu_in_flg), .o_alu_block_cy_ov(alu_block),
    .i_alu_res(alu_res), .i_alu_out_flg(alu_out_flg)
  );

  // Plain W-bit ALU; flag bits other than CY carry noise the sequencer must ignore.
  always_comb begin
    alu_c   = 1'b0;
    alu_res = '0;
    case (alu_opcode)
      3'd0: {alu_c, alu_res} = {1'b0, alu_arg1} + {1'b0, alu_arg2};
      3'd1: begin alu_res = alu_arg1 - alu_arg2; alu_c = (alu_arg1 < alu_arg2); end
      3'd2: alu_res = alu_arg1 & alu_arg2;
      3'd3: alu_res = alu_arg1 | alu_arg2;
      3'd4: alu_res = alu_arg1 ^ alu_arg2;
      3'd5: alu_res = ~alu_arg1;
      default: alu_res = alu_arg2;
    endcase
    alu_out_flg = {junk[3], alu_c, junk[2:0]};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction against the reference model; hold = cycles of rsp stall.
  task automatic do_op(input logic [2:0] op, input logic wide, input logic [31:0] a,
                       input logic [31:0] b, input int hold);
    longint unsigned aa, bb, mask, full, r;
    int n, lat, exp_lat;
    logic cy, ov, rm, am, bm, locy;
    logic [4:0] ef;
    n    = wide ? 32 : 16;
    mask = (64'd1 << n) - 1;
    aa   = wide ? {32'd0, a} : {48'd0, a[15:0]};
    bb   = wide ? {32'd0, b} : {48'd0, b[15:0]};
    cy = 1'b0; ov = 1'b0;
    case (op)
      3'd0: begin full = aa + bb; r = full & mask; cy = full[n]; end
      3'd1: begin r = (aa - bb) & mask; cy = (aa < bb); end
      3'd2: r = aa & bb;
      3'd3: r = aa | bb;
      3'd4: r = aa ^ bb;
      3'd5: r = ~aa & mask;
      default: r = bb;
    endcase
    am = aa[n-1]; bm = bb[n-1]; rm = r[n-1];
    if (op == 3'd0) ov = (am == bm) && (rm != am);
    if (op == 3'd1) ov = (am != bm) && (rm != am);
    if (op[2] & op[1]) ef = {(r == 0), m_flg[3], rm, ^r[31:0], m_flg[0]};
    else               ef = {(r == 0), cy, rm, ^r[31:0], ov};
    locy = (op == 3'd0) ? ({1'b0, a[15:0]} + {1'b0, b[15:0]} > 17'h0FFFF)
                        : (a[15:0] < b[15:0]);
    exp_lat = !wide ? 2 : ((op <= 3'd1) && locy) ? 4 : 3;

    @(negedge clk);
    chk("idle_req_ready", req_ready, 1);
    chk("idle_alu_drive", {alu_opcode, alu_arg1, alu_arg2}, 0);
    junk = 4'($urandom);
    req_valid = 1'b1; req_opcode = op; req_wide = wide; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0; req_a = $urandom; req_b = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 12) begin @(negedge clk); lat++; end
    chk("latency", lat, exp_lat);
    chk("rsp_res", rsp_res, r[31:0]);
    chk("rsp_flg", rsp_flg, ef);
    chk("alu_in_flg", alu_in_flg, ef);
    chk("busy_req_ready", req_ready, 0);
    m_flg = ef; l_res = rsp_res; l_flg = rsp_flg;
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {rsp_valid, req_ready}, 2'b10);
      chk("hold_res", rsp_res, r[31:0]);
      chk("hold_flg", rsp_flg, ef);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_hs", {rsp_valid, req_ready}, 2'b01);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_opcode = '0; req_wide = 1'b0;
    req_a = '0; req_b = '0; junk = '0; m_flg = 5'b0; l_res = '0; l_flg = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready_valid", {req_ready, rsp_valid}, 2'b10);
    chk("rst_res", rsp_res, 0);
    chk("rst_flg", rsp_flg, 0);
    chk("rst_alu", {alu_opcode, alu_arg1, alu_arg2, alu_block}, 0);
    rst_n = 1'b1;

    // wide add with carry out of the low half
    do_op(3'd0, 1'b1, 32'h0000_FFFF, 32'h0000_0001, 0);
    chk("t1_res", l_res, 32'h0001_0000);
    chk("t1_flg", l_flg, 5'b00010);
    // signed overflow into the top bit
    do_op(3'd0, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    chk("t3_res", l_res, 32'h8000_0000);
    chk("t3_flg", l_flg, 5'b00111);
    // narrow and, upper halves must be ignored
    do_op(3'd2, 1'b0, 32'hFFFF_00F0, 32'hFFFF_0F00, 0);
    chk("t4_res", l_res, 32'h0000_0000);
    chk("t4_flg", l_flg, 5'b10000);
    // wide sub borrowing through FIX
    do_op(3'd1, 1'b1, 32'h0000_0000, 32'h0000_0001, 0);
    chk("t2_res", l_res, 32'hFFFF_FFFF);
    chk("t2_flg", l_flg, 5'b01100);
    // pass keeps CY/OV; response stalled 5 cycles
    do_op(3'd6, 1'b0, 32'hABCD_5555, 32'h0000_1234, 5);
    chk("t5_res", l_res, 32'h0000_1234);
    chk("t5_flg", l_flg, 5'b01010);

    // reset in the middle of a wide add (during HI)
    @(negedge clk);
    req_valid = 1'b1; req_opcode = 3'd0; req_wide = 1'b1; req_a = 32'h0001_FFFF; req_b = 32'h0000_0001;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("t6_hi_drive", {alu_opcode, alu_arg1, alu_arg2}, {3'd0, 16'h0001, 16'h0000});
    rst_n = 1'b0;
    #1;
    chk("t6_rst_flg", rsp_flg, 0);
    chk("t6_rst_state", {rsp_valid, req_ready}, 2'b01);
    m_flg = 5'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(3'd0, 1'b0, 32'h0000_0003, 32'h0000_0004, 0);
    chk("t6_res", l_res, 32'h0000_0007);
    chk("t6_flg", l_flg, 5'b00010);

    // randomized traffic
    for (int k = 0; k < 60; k++)
      do_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, $urandom,
            $urandom_range(0, 2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
